// File: rtl/sequence_checker_pkg.sv
// Shared types and helpers for the wrapping sequence-number checker.
package sequence_checker_pkg;

    typedef enum logic [0:0] {
        ST_LOCKED = 1'b0,
        ST_ERROR  = 1'b1
    } seq_state_e;

    typedef enum logic [2:0] {
        CLS_NONE    = 3'd0,
        CLS_MATCH   = 3'd1,
        CLS_GAP     = 3'd2,
        CLS_DUP     = 3'd3,
        CLS_INVALID = 3'd4
    } seq_class_e;

    function automatic bit is_pow2(input int n);
        return (n > 0) && ((n & (n - 1)) == 0);
    endfunction

endpackage

// File: rtl/sequence_checker.sv
// Receive-side checker for wrapping sequence numbers: classifies each valid
// input as match, gap, duplicate or invalid against a modulo-RANGE expectation.
module sequence_checker
    import sequence_checker_pkg::*;
#(
    parameter int RANGE           = 4,
    parameter int RANGE_LOG2      = $clog2(RANGE),
    parameter int RESET_VALUE     = 0,
    parameter bit RESYNC_ON_ERROR = 1'b1
) (
    input  logic                  i_clock,
    input  logic                  i_resetn,
    input  logic                  i_valid,
    input  logic [RANGE_LOG2-1:0] i_sequence,
    input  logic                  i_clear_error,
    output logic [RANGE_LOG2-1:0] o_expected,
    output logic                  o_match,
    output logic                  o_gap,
    output logic                  o_duplicate,
    output logic                  o_invalid,
    output logic [RANGE_LOG2-1:0] o_skipped,
    output logic                  o_error_sticky,
    output logic                  o_locked
);

    localparam bit                    RANGE_IS_POW2 = is_pow2(RANGE);
    localparam logic [RANGE_LOG2:0]   RANGE_W       = (RANGE_LOG2 + 1)'(RANGE);
    localparam logic [RANGE_LOG2:0]   DUP_DIST      = (RANGE_LOG2 + 1)'(RANGE - 1);
    localparam logic [RANGE_LOG2:0]   ZERO_DIST     = {(RANGE_LOG2 + 1){1'b0}};
    localparam logic [RANGE_LOG2-1:0] LAST_VALUE    = RANGE_LOG2'(RANGE - 1);
    localparam logic [RANGE_LOG2-1:0] RST_VALUE     = RANGE_LOG2'(RESET_VALUE);

    function automatic logic [RANGE_LOG2-1:0] wrap_inc(input logic [RANGE_LOG2-1:0] x);
        if (x == LAST_VALUE) begin
            return {RANGE_LOG2{1'b0}};
        end else begin
            return x + RANGE_LOG2'(1);
        end
    endfunction

    seq_state_e            r_state;
    seq_state_e            w_next_state;
    seq_state_e            w_lock_state;
    seq_class_e            w_class;
    logic [RANGE_LOG2-1:0] r_expected;
    logic [RANGE_LOG2-1:0] w_next_expected;
    logic [RANGE_LOG2-1:0] r_skipped;
    logic [RANGE_LOG2-1:0] w_next_skipped;
    logic                  r_sticky;
    logic                  w_next_sticky;
    logic [3:0]            r_pulses;
    logic [3:0]            w_next_pulses;
    logic [RANGE_LOG2:0]   w_seq_ext;
    logic [RANGE_LOG2:0]   w_exp_ext;
    logic [RANGE_LOG2:0]   w_distance;
    logic                  w_invalid;
    logic                  w_eval;

    assign w_seq_ext  = {1'b0, i_sequence};
    assign w_exp_ext  = {1'b0, r_expected};
    assign w_distance = (w_seq_ext >= w_exp_ext) ? (w_seq_ext - w_exp_ext)
                                                 : (w_seq_ext + RANGE_W - w_exp_ext);

    // Out-of-range codes only exist when RANGE leaves unused encodings.
    generate
        if (!RANGE_IS_POW2) begin : g_invalid
            assign w_invalid = (w_seq_ext >= RANGE_W);
        end else begin : g_no_invalid
            assign w_invalid = 1'b0;
        end
    endgenerate

    // clear_error re-opens evaluation in the same cycle it is asserted.
    assign w_eval       = i_valid && ((r_state == ST_LOCKED) || i_clear_error);
    assign w_lock_state = i_clear_error ? ST_LOCKED : r_state;

    // Next-state, classification and bookkeeping for the current input.
    always_comb begin
        w_next_state    = w_lock_state;
        w_next_expected = r_expected;
        w_next_skipped  = r_skipped;
        w_next_sticky   = r_sticky & ~i_clear_error;
        w_class         = CLS_NONE;
        if (w_eval) begin
            if (w_invalid) begin
                w_class       = CLS_INVALID;
                w_next_sticky = 1'b1;
                w_next_state  = RESYNC_ON_ERROR ? w_lock_state : ST_ERROR;
            end else if (w_distance == ZERO_DIST) begin
                w_class         = CLS_MATCH;
                w_next_expected = wrap_inc(r_expected);
            end else if ((RANGE > 2) && (w_distance == DUP_DIST)) begin
                w_class       = CLS_DUP;
                w_next_sticky = 1'b1;
            end else begin
                w_class         = CLS_GAP;
                w_next_sticky   = 1'b1;
                w_next_skipped  = w_distance[RANGE_LOG2-1:0];
                w_next_expected = RESYNC_ON_ERROR ? wrap_inc(i_sequence) : r_expected;
                w_next_state    = RESYNC_ON_ERROR ? w_lock_state : ST_ERROR;
            end
        end else begin
            w_class = CLS_NONE;
        end
    end

    // Decode the classification into the one-hot pulse vector {match, gap, dup, invalid}.
    always_comb begin
        w_next_pulses = 4'b0000;
        case (w_class)
            CLS_MATCH:   w_next_pulses = 4'b1000;
            CLS_GAP:     w_next_pulses = 4'b0100;
            CLS_DUP:     w_next_pulses = 4'b0010;
            CLS_INVALID: w_next_pulses = 4'b0001;
            default:     w_next_pulses = 4'b0000;
        endcase
    end

    // State and output registers.
    always_ff @(posedge i_clock or negedge i_resetn) begin
        if (!i_resetn) begin
            r_state    <= ST_LOCKED;
            r_expected <= RST_VALUE;
            r_skipped  <= {RANGE_LOG2{1'b0}};
            r_sticky   <= 1'b0;
            r_pulses   <= 4'b0000;
        end else begin
            r_state    <= w_next_state;
            r_expected <= w_next_expected;
            r_skipped  <= w_next_skipped;
            r_sticky   <= w_next_sticky;
            r_pulses   <= w_next_pulses;
        end
    end

    assign o_expected     = r_expected;
    assign o_skipped      = r_skipped;
    assign o_error_sticky = r_sticky;
    assign o_match        = r_pulses[3];
    assign o_gap          = r_pulses[2];
    assign o_duplicate    = r_pulses[1];
    assign o_invalid      = r_pulses[0];
    assign o_locked       = (r_state == ST_LOCKED);

endmodule

// File: tb/tb_sequence_checker.sv
// Self-checking bench: three checker configurations driven from scripted steps,
// with expected output vectors queued on drive and popped after each edge.
module tb_sequence_checker;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rstn;

    // A: RANGE=5 resync, B: RANGE=4 lock-on-error, C: RANGE=8 resync.
    logic       a_v, a_clr, b_v, b_clr, c_v, c_clr;
    logic [2:0] a_seq, c_seq;
    logic [1:0] b_seq;
    logic [2:0] a_exp, a_skp, c_exp, c_skp;
    logic [1:0] b_exp, b_skp;
    logic a_m, a_g, a_d, a_i, a_s, a_l;
    logic b_m, b_g, b_d, b_i, b_s, b_l;
    logic c_m, c_g, c_d, c_i, c_s, c_l;

    sequence_checker #(.RANGE(5), .RESET_VALUE(0), .RESYNC_ON_ERROR(1'b1)) u_a (
        .i_clock(clk), .i_resetn(rstn), .i_valid(a_v), .i_sequence(a_seq),
        .i_clear_error(a_clr), .o_expected(a_exp), .o_match(a_m), .o_gap(a_g),
        .o_duplicate(a_d), .o_invalid(a_i), .o_skipped(a_skp),
        .o_error_sticky(a_s), .o_locked(a_l));

    sequence_checker #(.RANGE(4), .RESET_VALUE(0), .RESYNC_ON_ERROR(1'b0)) u_b (
        .i_clock(clk), .i_resetn(rstn), .i_valid(b_v), .i_sequence(b_seq),
        .i_clear_error(b_clr), .o_expected(b_exp), .o_match(b_m), .o_gap(b_g),
        .o_duplicate(b_d), .o_invalid(b_i), .o_skipped(b_skp),
        .o_error_sticky(b_s), .o_locked(b_l));

    sequence_checker #(.RANGE(8), .RESET_VALUE(0), .RESYNC_ON_ERROR(1'b1)) u_c (
        .i_clock(clk), .i_resetn(rstn), .i_valid(c_v), .i_sequence(c_seq),
        .i_clear_error(c_clr), .o_expected(c_exp), .o_match(c_m), .o_gap(c_g),
        .o_duplicate(c_d), .o_invalid(c_i), .o_skipped(c_skp),
        .o_error_sticky(c_s), .o_locked(c_l));

    typedef struct {
        int         dut;
        logic       v;
        int         seq;
        logic       clr;
        logic [11:0] e;
        string      tag;
    } step_t;

    typedef struct {
        int          dut;
        logic [11:0] e;
        string       tag;
    } sb_t;

    sb_t sb[$];
    int  n_tests = 0;
    int  n_fail  = 0;

    // Expected vector: {expected, skipped, match, gap, dup, invalid, sticky, locked}
    function automatic logic [11:0] mk(input int e, input int s, input logic [5:0] f);
        return {3'(e), 3'(s), f};
    endfunction

    function automatic logic [11:0] obs(input int d);
        case (d)
            0:       return {a_exp, a_skp, a_m, a_g, a_d, a_i, a_s, a_l};
            1:       return {1'b0, b_exp, 1'b0, b_skp, b_m, b_g, b_d, b_i, b_s, b_l};
            default: return {c_exp, c_skp, c_m, c_g, c_d, c_i, c_s, c_l};
        endcase
    endfunction

    task automatic idle();
        a_v = 1'b0; a_clr = 1'b0; a_seq = 3'd0;
        b_v = 1'b0; b_clr = 1'b0; b_seq = 2'd0;
        c_v = 1'b0; c_clr = 1'b0; c_seq = 3'd0;
    endtask

    // Drive one cycle on one instance, queue what it must show afterwards.
    task automatic step(input step_t t);
        idle();
        case (t.dut)
            0:       begin a_v = t.v; a_seq = 3'(t.seq); a_clr = t.clr; end
            1:       begin b_v = t.v; b_seq = 2'(t.seq); b_clr = t.clr; end
            default: begin c_v = t.v; c_seq = 3'(t.seq); c_clr = t.clr; end
        endcase
        sb.push_back('{t.dut, t.e, t.tag});
        @(posedge clk);
        #1;
        idle();
    endtask

    task automatic test_reset();
        sb_t ent;
        logic [11:0] got;
        idle();
        rstn = 1'b0;
        #23;
        for (int d = 0; d < 3; d++) sb.push_back('{d, mk(0, 0, 6'b000001), "reset"});
        while (sb.size() > 0) begin
            ent = sb.pop_front();
            got = obs(ent.dut);
            n_tests++;
            if (got !== ent.e) begin
                n_fail++;
                $display("FAIL %s dut%0d: observed %h required %h", ent.tag, ent.dut, got, ent.e);
            end
        end
        rstn = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_back_to_back();
        step_t t[$];
        sb_t ent;
        logic [11:0] got;
        int seqs[7] = '{0, 1, 2, 3, 4, 0, 1};
        int exps[7] = '{1, 2, 3, 4, 0, 1, 2};
        for (int i = 0; i < 7; i++) t.push_back('{0, 1'b1, seqs[i], 1'b0, mk(exps[i], 0, 6'b100001), "b2b_match"});
        t.push_back('{0, 1'b0, 0, 1'b0, mk(2, 0, 6'b000001), "b2b_idle"});
        foreach (t[i]) begin
            step(t[i]);
            ent = sb.pop_front();
            got = obs(ent.dut);
            n_tests++;
            if (got !== ent.e) begin
                n_fail++;
                $display("FAIL %s[%0d]: observed %h required %h", ent.tag, i, got, ent.e);
            end
        end
    endtask

    task automatic test_gap_clear();
        step_t t[$];
        sb_t ent;
        logic [11:0] got;
        t.push_back('{0, 1'b1, 2, 1'b0, mk(3, 0, 6'b100001), "gap_pre"});
        t.push_back('{0, 1'b1, 1, 1'b0, mk(2, 3, 6'b010011), "gap"});
        t.push_back('{0, 1'b0, 0, 1'b1, mk(2, 3, 6'b000001), "gap_clear"});
        foreach (t[i]) begin
            step(t[i]);
            ent = sb.pop_front();
            got = obs(ent.dut);
            n_tests++;
            if (got !== ent.e) begin
                n_fail++;
                $display("FAIL %s: observed %h required %h", ent.tag, got, ent.e);
            end
        end
    endtask

    task automatic test_dup_invalid();
        step_t t[$];
        sb_t ent;
        logic [11:0] got;
        t.push_back('{0, 1'b1, 2, 1'b0, mk(3, 3, 6'b100001), "dup_pre"});
        t.push_back('{0, 1'b1, 2, 1'b0, mk(3, 3, 6'b001011), "dup"});
        t.push_back('{0, 1'b1, 6, 1'b0, mk(3, 3, 6'b000111), "invalid6"});
        t.push_back('{0, 1'b1, 7, 1'b0, mk(3, 3, 6'b000111), "invalid7"});
        t.push_back('{0, 1'b1, 3, 1'b0, mk(4, 3, 6'b100011), "dup_post"});
        t.push_back('{0, 1'b0, 0, 1'b1, mk(4, 3, 6'b000001), "dup_clear"});
        t.push_back('{2, 1'b1, 7, 1'b0, mk(0, 0, 6'b001011), "r8_dup"});
        t.push_back('{2, 1'b1, 5, 1'b0, mk(6, 5, 6'b010011), "r8_gap"});
        t.push_back('{2, 1'b1, 6, 1'b0, mk(7, 5, 6'b100011), "r8_match"});
        t.push_back('{2, 1'b1, 7, 1'b0, mk(0, 5, 6'b100011), "r8_wrap"});
        foreach (t[i]) begin
            step(t[i]);
            ent = sb.pop_front();
            got = obs(ent.dut);
            n_tests++;
            if (got !== ent.e) begin
                n_fail++;
                $display("FAIL %s: observed %h required %h", ent.tag, got, ent.e);
            end
        end
    endtask

    task automatic test_lock_on_error();
        step_t t[$];
        sb_t ent;
        logic [11:0] got;
        t.push_back('{1, 1'b1, 0, 1'b0, mk(1, 0, 6'b100001), "lk_match"});
        t.push_back('{1, 1'b1, 3, 1'b0, mk(1, 2, 6'b010010), "lk_gap"});
        t.push_back('{1, 1'b1, 1, 1'b0, mk(1, 2, 6'b000010), "lk_ignored1"});
        t.push_back('{1, 1'b1, 2, 1'b0, mk(1, 2, 6'b000010), "lk_ignored2"});
        t.push_back('{1, 1'b1, 1, 1'b1, mk(2, 2, 6'b100001), "lk_clear_match"});
        t.push_back('{1, 1'b1, 0, 1'b1, mk(2, 2, 6'b010010), "lk_clear_gap"});
        t.push_back('{1, 1'b0, 0, 1'b1, mk(2, 2, 6'b000001), "lk_clear"});
        t.push_back('{1, 1'b1, 2, 1'b0, mk(3, 2, 6'b100001), "lk_match2"});
        t.push_back('{1, 1'b1, 3, 1'b0, mk(0, 2, 6'b100001), "lk_wrap"});
        foreach (t[i]) begin
            step(t[i]);
            ent = sb.pop_front();
            got = obs(ent.dut);
            n_tests++;
            if (got !== ent.e) begin
                n_fail++;
                $display("FAIL %s: observed %h required %h", ent.tag, got, ent.e);
            end
        end
    endtask

    task automatic test_midstream_reset();
        step_t t[$];
        sb_t ent;
        logic [11:0] got;
        t.push_back('{0, 1'b1, 4, 1'b0, mk(0, 3, 6'b100001), "mr_pre4"});
        t.push_back('{0, 1'b1, 0, 1'b0, mk(1, 3, 6'b100001), "mr_pre0"});
        t.push_back('{0, 1'b1, 1, 1'b0, mk(2, 3, 6'b100001), "mr_pre1"});
        t.push_back('{0, 1'b1, 2, 1'b0, mk(3, 3, 6'b100001), "mr_pre2"});
        foreach (t[i]) begin
            step(t[i]);
            ent = sb.pop_front();
            got = obs(ent.dut);
            n_tests++;
            if (got !== ent.e) begin
                n_fail++;
                $display("FAIL %s: observed %h required %h", ent.tag, got, ent.e);
            end
        end
        #3;
        rstn = 1'b0;
        #1;
        sb.push_back('{0, mk(0, 0, 6'b000001), "mr_async"});
        ent = sb.pop_front();
        got = obs(ent.dut);
        n_tests++;
        if (got !== ent.e) begin
            n_fail++;
            $display("FAIL %s: observed %h required %h", ent.tag, got, ent.e);
        end
        #2;
        rstn = 1'b1;
        step('{0, 1'b1, 0, 1'b0, mk(1, 0, 6'b100001), "mr_after"});
        ent = sb.pop_front();
        got = obs(ent.dut);
        n_tests++;
        if (got !== ent.e) begin
            n_fail++;
            $display("FAIL %s: observed %h required %h", ent.tag, got, ent.e);
        end
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_gap_clear();
        test_dup_invalid();
        test_lock_on_error();
        test_midstream_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
